// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC ownership, synchronous imem drive, stall/redirect handling.
// Optional delivered-instruction counter enabled by defining FETCH_CNT_EN.
module fetch_stage #(
  parameter int             N        = 32,
  parameter int             AW       = 14,
  parameter logic [N-1:0]   RESET_PC = 32'h4000_0000,
  parameter logic [N-1:0]   NOP      = 32'h0000_0013
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          redirect,
  input  logic [N-1:0]  redirect_pc,
  output logic [AW-1:0] imem_addr,
  output logic          imem_en,
  input  logic [N-1:0]  imem_dout,
  output logic [N-1:0]  instr_d,
  output logic [N-1:0]  pc_d,
  output logic          valid_d,
  output logic [1:0]    imm_sel_d,
  output logic [31:0]   fetch_cnt
);

  logic [N-1:0] pc_f;
  logic [N-1:0] pc_next;
  logic         vld_f;
  logic         kill;

  // While vld_f is still low the reset-vector word is being re-read, so the PC
  // holds; otherwise the word at RESET_PC would be squashed and never delivered.
  always_comb begin
    pc_next = pc_f + N'(4);
    if (rst)
      pc_next = RESET_PC;
    else if (redirect)
      pc_next = {redirect_pc[N-1:2], 2'b00};
    else if (stall || !vld_f)
      pc_next = pc_f;
  end

  assign imem_addr = pc_next[AW+1:2];
  assign imem_en   = rst | redirect | ~stall;

  always_ff @(posedge clk) begin
    pc_f <= pc_next;
    if (rst)
      vld_f <= 1'b0;
    else
      vld_f <= 1'b1;
  end

  // The word in decode during a redirect is wrong-path and is squashed here.
  assign kill    = redirect | ~vld_f;
  assign valid_d = ~kill;
  assign instr_d = kill ? NOP : imem_dout;
  assign pc_d    = pc_f;

  always_comb begin
    imm_sel_d = 2'd0;
    case (instr_d[6:0])
      7'b0100011: imm_sel_d = 2'd1;
      7'b1100011: imm_sel_d = 2'd2;
      7'b0110111,
      7'b0010111: imm_sel_d = 2'd3;
      default:    imm_sel_d = 2'd0;
    endcase
  end

`ifdef FETCH_CNT_EN
  logic [31:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst)
      cnt_q <= 32'd0;
    else if (valid_d && !stall)
      cnt_q <= cnt_q + 32'd1;
  end

  assign fetch_cnt = cnt_q;
`else
  assign fetch_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage with a synchronous-read imem model.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [13:0] imem_addr;
  logic        imem_en;
  logic [31:0] imem_dout;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic        valid_d;
  logic [1:0]  imm_sel_d;
  logic [31:0] fetch_cnt;

  int compared   = 0;
  int mismatched = 0;

  localparam logic [31:0] NOPW  = 32'h0000_0013;
  localparam logic [31:0] RSTPC = 32'h4000_0000;

  fetch_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_en(imem_en),
    .imem_dout(imem_dout), .instr_d(instr_d), .pc_d(pc_d), .valid_d(valid_d),
    .imm_sel_d(imm_sel_d), .fetch_cnt(fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Program image: addi/sw/beq/lui/jal at the reset vector, auipc-style filler elsewhere.
  function automatic logic [31:0] memWord(input logic [13:0] a);
    case (a)
      14'd0:   memWord = 32'h0010_0093;
      14'd1:   memWord = 32'h0011_2023;
      14'd2:   memWord = 32'h0000_0063;
      14'd3:   memWord = 32'h1234_50B7;
      14'd4:   memWord = 32'h0000_006F;
      default: memWord = {4'hA, a, 7'h00, 7'b0010111};
    endcase
  endfunction

  always @(posedge clk)
    if (imem_en) imem_dout <= memWord(imem_addr);

  function automatic logic [31:0] expCnt(input int n);
`ifdef FETCH_CNT_EN
    expCnt = 32'(n);
`else
    expCnt = 32'd0;
`endif
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic s, input logic rd, input logic [31:0] rpc);
    rst         = r;
    stall       = s;
    redirect    = rd;
    redirect_pc = rpc;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks the decode-side outputs for one cycle.
  task automatic checkDecode(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                             input logic v, input logic [1:0] sel, input int cnt);
    checkOutput({tag, ".pc_d"},    pc_d, pc);
    checkOutput({tag, ".instr_d"}, instr_d, ins);
    checkOutput({tag, ".valid_d"}, 32'(valid_d), 32'(v));
    checkOutput({tag, ".imm_sel"}, 32'(imm_sel_d), 32'(sel));
    checkOutput({tag, ".cnt"},     fetch_cnt, expCnt(cnt));
  endtask

  logic [1:0] selTab [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

  initial begin
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    repeat (3) tick();

    // Reset state
    checkDecode("rst", RSTPC, NOPW, 1'b0, 2'd0, 0);
    checkOutput("rst.imem_addr", 32'(imem_addr), 32'h0);
    checkOutput("rst.imem_en", 32'(imem_en), 32'h1);

    // First cycle after release: reset vector still in flight
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("rel1.imem_addr", 32'(imem_addr), 32'h0);
    checkOutput("rel1.valid_d", 32'(valid_d), 32'h0);
    tick();

    // Free-run with a 3-cycle stall at pc_d=4000_0008
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        for (int k = 0; k < 3; k++) begin
          applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
          checkDecode("stall", 32'h4000_0008, 32'h0000_0063, 1'b1, 2'd2, 2);
          checkOutput("stall.imem_en", 32'(imem_en), 32'h0);
          checkOutput("stall.imem_addr", 32'(imem_addr), 32'h2);
          tick();
        end
      end
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
      checkDecode("run", RSTPC + 32'(4 * i), memWord(14'(i)), 1'b1, selTab[i], i);
      checkOutput("run.imem_addr", 32'(imem_addr), 32'(i + 1));
      tick();
    end

    // Redirect to 0x1003 (low bits dropped)
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_1003);
    checkDecode("redir", 32'h4000_0014, NOPW, 1'b0, 2'd0, 5);
    checkOutput("redir.imem_addr", 32'(imem_addr), 32'h400);
    checkOutput("redir.imem_en", 32'(imem_en), 32'h1);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkDecode("redir+1", 32'h0000_1000, memWord(14'h400), 1'b1, 2'd3, 5);
    tick();

    // Redirect while stalled, stall persists two more cycles
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_2000);
    checkOutput("srd.imem_en", 32'(imem_en), 32'h1);
    checkOutput("srd.imem_addr", 32'(imem_addr), 32'h800);
    checkOutput("srd.valid_d", 32'(valid_d), 32'h0);
    tick();
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
      checkDecode("srd.hold", 32'h0000_2000, memWord(14'h800), 1'b1, 2'd3, 6);
      checkOutput("srd.hold.imem_en", 32'(imem_en), 32'h0);
      tick();
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkDecode("srd.go", 32'h0000_2000, memWord(14'h800), 1'b1, 2'd3, 6);
    tick();

    // Back-to-back redirects: only the last yields a valid word
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_3000);
    checkOutput("b2b1.valid_d", 32'(valid_d), 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_5004);
    checkDecode("b2b2", 32'h0000_3000, NOPW, 1'b0, 2'd0, 7);
    checkOutput("b2b2.imem_addr", 32'(imem_addr), 32'h1401);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkDecode("b2b3", 32'h0000_5004, memWord(14'h1401), 1'b1, 2'd3, 7);
    tick();

    // PC wrap at the top of the address space
    applyStimulus(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF);
    checkOutput("wrap.imem_addr", 32'(imem_addr), 32'h3FFF);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkDecode("wrap0", 32'hFFFF_FFFC, memWord(14'h3FFF), 1'b1, 2'd3, 8);
    checkOutput("wrap0.imem_addr", 32'(imem_addr), 32'h0);
    tick();
    checkDecode("wrap1", 32'h0000_0000, 32'h0010_0093, 1'b1, 2'd0, 9);
    tick();

    // Reset mid-operation
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("mrst.imem_addr", 32'(imem_addr), 32'h0);
    tick();
    checkDecode("mrst", RSTPC, NOPW, 1'b0, 2'd0, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("mrst.rel.valid_d", 32'(valid_d), 32'h0);
    tick();
    checkDecode("mrst.rel2", RSTPC, 32'h0010_0093, 1'b1, 2'd0, 0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
